ifcfg_loader: RTL and testbench

Configuration loader between the off-chip configuration interface and the central control unit. When the control unit requests configuration, it reads a header word and a fixed number of words per layer over a valid/ready stream into a per-layer register file. It then signals read-done to the control unit. On each layer reset from the control unit, it presents the parameters of the current layer.

---
 rtl/ifcfg_loader.sv | 144 ++++++++++++++
 tb/tb_ifcfg_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifcfg_loader.sv
// Configuration loader: pulls a header plus four words per layer from a valid/ready
// stream into a per-layer register file and presents the active layer to the control unit.
module ifcfg_loader #(
    parameter int IF_WIDTH        = 32,
    parameter int NUM_LAYER       = 16,
    parameter int WORDS_PER_LAYER = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                CFG_Req,
    input  logic [IF_WIDTH-1:0]                 IF_Dat,
    input  logic                                IF_DatVld,
    output logic                                IF_DatRdy,
    output logic                                IFCFG_RdDone,
    output logic                                IFCFG_Val,
    input  logic                                Rst_Layer,
    output logic [$clog2(NUM_LAYER)-1:0]        CFG_LayIdx,
    output logic [WORDS_PER_LAYER*IF_WIDTH-1:0] CFG_Dat,
    output logic                                CFG_LastLay,
    output logic                                CFG_Err
);

    localparam int LW = $clog2(NUM_LAYER);
    localparam int NW = LW + 1;                     // holds a layer count up to NUM_LAYER
    localparam int CW = $clog2(4 * NUM_LAYER) + 1;  // word counter

    typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, HOLD} state_t;

    state_t state_q, state_d;

    logic [CW-1:0]       cnt_q;
    logic [NW-1:0]       nlay_q;
    logic [LW-1:0]       idx_q;
    logic                first_q;
    logic                val_q;
    logic                err_q;

    logic [7:0]          hdr_n;
    logic [NW-1:0]       hdr_cnt;
    logic                hdr_err;
    logic                last_word;
    logic                last_lay;
    logic                start;

    logic [IF_WIDTH-1:0] regfile [NUM_LAYER][WORDS_PER_LAYER];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign last_word = (cnt_q == ({nlay_q, 2'b00} - CW'(1)));

    // NOTE: defaults at the top of every always_comb keep each path assigned, so no latches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (CFG_Req)                 state_d = HDR;
            HDR:     if (IF_DatVld)               state_d = LOAD;
            LOAD:    if (IF_DatVld && last_word)  state_d = DONE;
            DONE:                                 state_d = HOLD;
            HOLD:    if (!CFG_Req)                state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    always_comb begin
        IF_DatRdy    = 1'b0;
        IFCFG_RdDone = 1'b0;
        unique case (state_q)
            HDR, LOAD: IF_DatRdy    = 1'b1;
            DONE:      IFCFG_RdDone = 1'b1;
            default:   ;
        endcase
    end

    // Header layer count is clamped into 1..NUM_LAYER; out-of-range values flag an error.
    assign hdr_n = IF_Dat[7:0];
    always_comb begin
        hdr_err = 1'b0;
        hdr_cnt = NW'(hdr_n);
        if (hdr_n == 8'd0) begin
            hdr_err = 1'b1;
            hdr_cnt = NW'(1);
        end else if (int'(hdr_n) > NUM_LAYER) begin
            hdr_err = 1'b1;
            hdr_cnt = NW'(NUM_LAYER);
        end
    end

    assign start    = (state_q == IDLE) && CFG_Req;
    assign last_lay = ({1'b0, idx_q} == (nlay_q - NW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            nlay_q  <= NW'(1);
            idx_q   <= '0;
            first_q <= 1'b0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (start) begin
                cnt_q   <= '0;
                idx_q   <= '0;
                first_q <= 1'b0;
                val_q   <= 1'b0;
                err_q   <= 1'b0;
            end else if (val_q && Rst_Layer) begin
                // First pulse after a load selects layer 0 without advancing.
                if (!first_q)      first_q <= 1'b1;
                else if (last_lay) idx_q   <= '0;
                else               idx_q   <= idx_q + LW'(1);
            end
            if (state_q == HDR && IF_DatVld) begin
                nlay_q <= hdr_cnt;
                err_q  <= hdr_err;
            end
            if (state_q == LOAD && IF_DatVld) begin
                cnt_q <= cnt_q + CW'(1);
                if (last_word) val_q <= 1'b1;
            end
        end
    end

    // NOTE: the register file has no reset; IFCFG_Val qualifies its contents.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && IF_DatVld)
            regfile[cnt_q[CW-2:2]][cnt_q[1:0]] <= IF_Dat;
    end

    always_comb begin
        CFG_Dat = '0;
        for (int j = 0; j < WORDS_PER_LAYER; j++)
            CFG_Dat[j*IF_WIDTH +: IF_WIDTH] = regfile[idx_q][j];
    end

    assign CFG_LayIdx  = idx_q;
    assign CFG_LastLay = last_lay;
    assign IFCFG_Val   = val_q;
    assign CFG_Err     = err_q;

endmodule

// File: tb/tb_ifcfg_loader.sv
// Self-checking bench for ifcfg_loader: header table, directed corner sequences and
// randomized loads compared against a per-layer array model of the stored configuration.
module tb_ifcfg_loader;

    localparam int IFW = 32;
    localparam int NL  = 16;
    localparam int LW  = $clog2(NL);
    localparam int DW  = 4 * IFW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_req;
    logic [IFW-1:0] if_dat;
    logic           if_dat_vld;
    logic           if_dat_rdy;
    logic           rddone;
    logic           val;
    logic           rst_layer;
    logic [LW-1:0]  lay_idx;
    logic [DW-1:0]  cfg_dat;
    logic           last_lay;
    logic           err;

    always #5 clk = ~clk;

    ifcfg_loader #(
        .IF_WIDTH       (IFW),
        .NUM_LAYER      (NL),
        .WORDS_PER_LAYER(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .CFG_Req     (cfg_req),
        .IF_Dat      (if_dat),
        .IF_DatVld   (if_dat_vld),
        .IF_DatRdy   (if_dat_rdy),
        .IFCFG_RdDone(rddone),
        .IFCFG_Val   (val),
        .Rst_Layer   (rst_layer),
        .CFG_LayIdx  (lay_idx),
        .CFG_Dat     (cfg_dat),
        .CFG_LastLay (last_lay),
        .CFG_Err     (err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: what the control unit should see, kept as plain arrays and counters.
    logic [IFW-1:0] m_mem [NL][4];
    bit             m_val;
    bit             m_first;
    bit             m_err;
    int             m_idx;
    int             m_n;

    typedef struct {
        logic [7:0] hdr;
        int         exp_n;
        bit         exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_dat(input int l);
        return {m_mem[l][3], m_mem[l][2], m_mem[l][1], m_mem[l][0]};
    endfunction

    task automatic model_reset();
        m_val   = 1'b0;
        m_first = 1'b0;
        m_err   = 1'b0;
        m_idx   = 0;
        m_n     = 1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdy"},     if_dat_rdy, 0);
        check({tag, "_rddone"},  rddone,     0);
        check({tag, "_val"},     val,        0);
        check({tag, "_idx"},     lay_idx,    0);
        check({tag, "_err"},     err,        0);
        check({tag, "_lastlay"}, last_lay,   1);
    endtask

    task automatic layer_step(input string tag);
        rst_layer = 1'b1;
        step();
        rst_layer = 1'b0;
        if (m_val) begin
            if (!m_first) m_first = 1'b1;
            else          m_idx   = (m_idx + 1) % m_n;
        end
        check({tag, "_idx"},     lay_idx,  m_idx);
        check({tag, "_lastlay"}, last_lay, (m_idx == m_n - 1));
        if (m_val) check({tag, "_dat"}, cfg_dat, exp_dat(m_idx));
    endtask

    task automatic drop_req();
        cfg_req    = 1'b0;
        if_dat_vld = 1'b0;
        step();
        step();
    endtask

    // Runs one load from IDLE; words are base, base+1, ... Returns transfers and the
    // observation index (cycles after CFG_Req was first sampled) where RdDone appeared.
    task automatic run_load(input logic [7:0] hdr, input logic [IFW-1:0] base,
                            input int vld_pct, input int rl_pct,
                            output int xfers, output int rd_step);
        int             n;
        int             sent;
        int             steps;
        int             last_xfer;
        bit             done;
        bit             vld;
        bit             xfer;
        logic [IFW-1:0] hword;
        n = (hdr == 8'd0) ? 1 : (int'(hdr) > NL) ? NL : int'(hdr);
        m_val   = 1'b0;
        m_first = 1'b0;
        m_idx   = 0;
        m_err   = (hdr == 8'd0) || (int'(hdr) > NL);
        m_n     = n;
        for (int l = 0; l < n; l++)
            for (int w = 0; w < 4; w++)
                m_mem[l][w] = base + IFW'(4 * l + w);
        hword      = $urandom;
        hword[7:0] = hdr;
        sent = 0; steps = 0; last_xfer = -1; done = 1'b0; rd_step = -1;
        cfg_req = 1'b1;
        while (!done && steps < 4000) begin
            vld        = ($urandom_range(0, 99) < vld_pct);
            if_dat_vld = vld;
            if (!vld)           if_dat = $urandom;
            else if (sent == 0) if_dat = hword;
            else                if_dat = base + IFW'(sent - 1);
            rst_layer = (steps > 0) && ($urandom_range(0, 99) < rl_pct);
            xfer      = vld && if_dat_rdy;
            step();
            steps++;
            if (xfer) begin
                sent++;
                last_xfer = steps;
            end
            if (rddone) begin
                done    = 1'b1;
                rd_step = steps;
            end
        end
        rst_layer  = 1'b0;
        if_dat_vld = 1'b0;
        xfers      = sent;
        if (!done) begin
            check("load_timeout", 0, 1);
        end else begin
            m_val = 1'b1;
            check("load_xfers",        sent,     4 * n + 1);
            check("rddone_after_last", rd_step,  last_xfer);
            check("load_val",          val,      1);
            check("load_err",          err,      m_err);
            check("load_idx",          lay_idx,  0);
            check("load_lastlay",      last_lay, (n == 1));
            check("load_dat0",         cfg_dat,  exp_dat(0));
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int xf;
        int rd;
        int k;
        logic [7:0] hdr;

        rst_n = 1'b0; cfg_req = 1'b0; if_dat = '0; if_dat_vld = 1'b0; rst_layer = 1'b0;
        model_reset();
        repeat (3) step();
        check_reset("reset");
        rst_n = 1'b1;
        step();
        layer_step("noload");

        // Basic two-layer load with valid held high.
        run_load(8'd2, 32'h10, 100, 0, xf, rd);
        check("basic_latency", rd,       10);
        check("basic_dat",     cfg_dat,  {32'h13, 32'h12, 32'h11, 32'h10});
        check("basic_lastlay", last_lay, 0);

        // Request held high: no second pulse, nothing consumed.
        if_dat_vld = 1'b1;
        if_dat     = 32'hdead_beef;
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_rddone", rddone,     0);
            check("hold_rdy",    if_dat_rdy, 0);
        end
        if_dat_vld = 1'b0;
        check("hold_val", val, 1);

        layer_step("basic_s1");
        check("basic_s1_dat", cfg_dat, {32'h13, 32'h12, 32'h11, 32'h10});
        layer_step("basic_s2");
        check("basic_s2_dat",  cfg_dat,  {32'h17, 32'h16, 32'h15, 32'h14});
        check("basic_s2_last", last_lay, 1);
        layer_step("basic_s3");
        check("basic_s3_idx", lay_idx, 0);

        // Drop and re-raise the request: Val clears and the header is requested again.
        cfg_req = 1'b0;
        step();
        check("drop_val_kept", val, 1);
        cfg_req = 1'b1;
        step();
        check("rereq_rdy", if_dat_rdy, 1);
        check("rereq_val", val,        0);

        // Header N=3, three words, then asynchronous reset mid-LOAD.
        if_dat_vld = 1'b1;
        if_dat     = 32'h3;
        step();
        for (int i = 0; i < 3; i++) begin
            if_dat = 32'h100 + IFW'(i);
            step();
        end
        rst_n = 1'b0;
        #1;
        check_reset("midload");
        model_reset();
        if_dat_vld = 1'b0;
        cfg_req    = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        layer_step("postreset_noload");
        run_load(8'd1, 32'h200, 100, 0, xf, rd);
        check("postreset_latency", rd, 6);
        drop_req();

        // Header table: count clamping and error flag.
        vecs[0] = '{hdr: 8'd2,   exp_n: 2,  exp_err: 1'b0};
        vecs[1] = '{hdr: 8'd0,   exp_n: 1,  exp_err: 1'b1};
        vecs[2] = '{hdr: 8'd200, exp_n: 16, exp_err: 1'b1};
        vecs[3] = '{hdr: 8'd1,   exp_n: 1,  exp_err: 1'b0};
        vecs[4] = '{hdr: 8'd16,  exp_n: 16, exp_err: 1'b0};
        vecs[5] = '{hdr: 8'd17,  exp_n: 16, exp_err: 1'b1};
        for (int v = 0; v < 6; v++) begin
            run_load(vecs[v].hdr, 32'h1000 * IFW'(v + 1), 100, 0, xf, rd);
            check("tbl_xfers",   xf,  4 * vecs[v].exp_n + 1);
            check("tbl_err",     err, vecs[v].exp_err);
            check("tbl_latency", rd,  4 * vecs[v].exp_n + 2);
            for (int j = 0; j <= vecs[v].exp_n; j++) layer_step("tbl_layer");
            drop_req();
        end

        // Stalled three-layer load.
        run_load(8'd3, $urandom, 50, 0, xf, rd);
        check("stall_xfers", xf, 13);
        for (int j = 0; j < 4; j++) layer_step("stall_layer");
        drop_req();

        // Randomized loads with stray Rst_Layer pulses during loading.
        for (int it = 0; it < 15; it++) begin
            hdr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(17, 255))
                                              : 8'($urandom_range(0, 16));
            run_load(hdr, $urandom, $urandom_range(25, 100), 20, xf, rd);
            k = $urandom_range(0, 2 * m_n + 1);
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 1) == 1) step();
                layer_step("rand_layer");
            end
            drop_req();
            if ($urandom_range(0, 1) == 1) layer_step("rand_idle_layer");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
